// File: rtl/uart_pkg.sv
// uart_pkg: ASCII control codes, line-editor state encoding and byte classification.
package uart_pkg;
    localparam logic [7:0] BEL = 8'h07;
    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] DEL = 8'h7F;

    typedef enum logic [1:0] {IDLE, PROC, ECHO, HOLD} state_t;

    function automatic logic is_print(input logic [7:0] b);
        return b >= SP && b <= 8'h7E;
    endfunction
endpackage

// File: rtl/uart_line_ram.sv
// uart_line_ram: DEPTH x 8 line buffer, one write port and one registered read port.
module uart_line_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/uart_line_edit.sv
// uart_line_edit: UART line editor (printable store, backspace, CR/LF line handoff).
// Echo to the TX FIFO is built only when UART_LINE_ECHO_EN is defined.
module uart_line_edit
    import uart_pkg::*;
#(
    parameter int LINE_LEN  = 64,
    parameter int ADDRWIDTH = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_fifo_rd_data,
    input  logic                 rx_fifo_ne,
    output logic                 rx_fifo_re,
    output logic [7:0]           tx_fifo_wr_data,
    output logic                 tx_fifo_we,
    input  logic                 tx_fifo_cf,
    output logic                 line_rdy,
    output logic [ADDRWIDTH:0]   line_len,
    input  logic                 line_ack,
    input  logic [ADDRWIDTH-1:0] line_rd_addr,
    output logic [7:0]           line_rd_data,
    output logic                 line_ovf
);
`ifdef UART_LINE_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif
    localparam logic [ADDRWIDTH:0] FULL = (ADDRWIDTH+1)'(LINE_LEN);

    state_t             state, state_nx;
    logic [7:0]         cur;
    logic [ADDRWIDTH:0] len, len_nx;
    logic [23:0]        eq, eq_nx;
    logic [1:0]         ecnt, ecnt_nx;
    logic               done, done_nx;
    logic               wr_en;

    uart_line_ram #(.DEPTH(LINE_LEN), .AW(ADDRWIDTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (len[ADDRWIDTH-1:0]),
        .wdata (cur),
        .raddr (line_rd_addr),
        .rdata (line_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            ecnt       <= '0;
            done       <= 1'b0;
            rx_fifo_re <= 1'b0;
        end else begin
            state      <= state_nx;
            len        <= len_nx;
            ecnt       <= ecnt_nx;
            done       <= done_nx;
            rx_fifo_re <= state == IDLE && rx_fifo_ne;
        end
    end

    // Echo queue shifts out LSB first; cur holds the byte popped on the IDLE->PROC edge.
    always_ff @(posedge clk) begin
        eq  <= eq_nx;
        cur <= state == IDLE ? rx_fifo_rd_data : cur;
    end

    always_comb begin
        state_nx = state;
        len_nx   = len;
        eq_nx    = eq;
        ecnt_nx  = ecnt;
        done_nx  = done;
        wr_en    = 1'b0;
        line_ovf = 1'b0;
        case (state)
            IDLE: state_nx = rx_fifo_ne ? PROC : IDLE;
            PROC: begin
                state_nx = IDLE;
                if (is_print(cur)) begin
                    wr_en    = len != FULL;
                    line_ovf = len == FULL;
                    len_nx   = wr_en ? len + 1'b1 : len;
                    eq_nx    = {16'h0000, wr_en ? cur : BEL};
                    ecnt_nx  = 2'd1;
                    state_nx = ECHO_EN ? ECHO : IDLE;
                end else if ((cur == BS || cur == DEL) && len != '0) begin
                    len_nx   = len - 1'b1;
                    eq_nx    = {BS, SP, BS};
                    ecnt_nx  = 2'd3;
                    state_nx = ECHO_EN ? ECHO : IDLE;
                end else if ((cur == CR || cur == LF) && len != '0) begin
                    eq_nx    = {8'h00, LF, CR};
                    ecnt_nx  = 2'd2;
                    done_nx  = 1'b1;
                    state_nx = ECHO_EN ? ECHO : HOLD;
                end
            end
            ECHO: begin
                if (!tx_fifo_cf) begin
                    eq_nx    = eq >> 8;
                    ecnt_nx  = ecnt - 2'd1;
                    state_nx = ecnt == 2'd1 ? (done ? HOLD : IDLE) : ECHO;
                end
            end
            HOLD: begin
                if (line_ack) begin
                    len_nx   = '0;
                    done_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    assign tx_fifo_we      = ECHO_EN && state == ECHO && !tx_fifo_cf;
    assign tx_fifo_wr_data = (ECHO_EN && state == ECHO) ? eq[7:0] : 8'h00;
    assign line_rdy        = state == HOLD;
    assign line_len        = len;
endmodule

// File: tb/tb_uart_line_edit.sv
// tb_uart_line_edit: scoreboard bench with a byte-level line-editor reference model.
module tb_uart_line_edit;
    localparam int LINE_LEN = 64;
    localparam int AW       = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_fifo_rd_data = 8'h00;
    logic          rx_fifo_ne = 1'b0;
    logic          rx_fifo_re;
    logic [7:0]    tx_fifo_wr_data;
    logic          tx_fifo_we;
    logic          tx_fifo_cf = 1'b0;
    logic          line_rdy;
    logic [AW:0]   line_len;
    logic          line_ack = 1'b0;
    logic [AW-1:0] line_rd_addr = '0;
    logic [7:0]    line_rd_data;
    logic          line_ovf;

    uart_line_edit #(.LINE_LEN(LINE_LEN), .ADDRWIDTH(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_fifo_rd_data (rx_fifo_rd_data),
        .rx_fifo_ne      (rx_fifo_ne),
        .rx_fifo_re      (rx_fifo_re),
        .tx_fifo_wr_data (tx_fifo_wr_data),
        .tx_fifo_we      (tx_fifo_we),
        .tx_fifo_cf      (tx_fifo_cf),
        .line_rdy        (line_rdy),
        .line_len        (line_len),
        .line_ack        (line_ack),
        .line_rd_addr    (line_rd_addr),
        .line_rd_data    (line_rd_data),
        .line_ovf        (line_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int exp_ovf = 0, n_ovf = 0, n_sent = 0, n_re = 0;
    bit cf_force = 1'b0, cf_rand = 1'b0, re_s = 1'b0;
    logic [7:0] rx_q[$], mline[$], exp_echo[$], exp_bytes[$];
    int exp_len[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic echo(input logic [7:0] b);
`ifdef UART_LINE_ECHO_EN
        exp_echo.push_back(b);
`else
        if (b == 8'hFF) exp_echo.push_back(b);
        exp_echo.delete();
`endif
    endtask

    // Reference model: applies the editing rules to a byte queue as each byte is issued.
    task automatic send(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mline.size() < LINE_LEN) begin
                mline.push_back(b);
                echo(b);
            end else begin
                exp_ovf++;
                echo(8'h07);
            end
        end else if ((b == 8'h08 || b == 8'h7F) && mline.size() > 0) begin
            void'(mline.pop_back());
            echo(8'h08); echo(8'h20); echo(8'h08);
        end else if ((b == 8'h0D || b == 8'h0A) && mline.size() > 0) begin
            echo(8'h0D); echo(8'h0A);
            exp_len.push_back(mline.size());
            foreach (mline[i]) exp_bytes.push_back(mline[i]);
            mline.delete();
        end
        rx_q.push_back(b);
        n_sent++;
    endtask

    task automatic send_str(input string s);
        foreach (s[i]) send(s[i]);
    endtask

    function automatic logic [7:0] rnd_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 65) return 8'($urandom_range(32, 126));
        if (r < 75) return r[0] ? 8'h08 : 8'h7F;
        if (r < 88) return r[0] ? 8'h0D : 8'h0A;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic drain();
        int t;
        t = 0;
        while ((rx_q.size() != 0 || exp_echo.size() != 0 || exp_len.size() != 0 || line_rdy) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
        if (t >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: rx_q=%0d echo=%0d lines=%0d after %0d cycles", rx_q.size(), exp_echo.size(), exp_len.size(), t);
        end
        check("ovf_count", n_ovf, exp_ovf);
        check("len_track", line_len, mline.size());
    endtask

    // Show-ahead RX FIFO model: pops when the DUT held rx_fifo_re in the cycle just ended.
    always @(negedge clk) re_s = rx_fifo_re;
    always @(posedge clk) begin
        bit p;
        p = re_s;
        #2;
        if (p) begin
            n_re++;
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_underflow: rx_fifo_re=1 with empty FIFO at %0t", $time);
            end else void'(rx_q.pop_front());
        end
        rx_fifo_ne = rx_q.size() != 0;
        rx_fifo_rd_data = rx_fifo_ne ? rx_q[0] : 8'h00;
    end

    always @(posedge clk) begin
        #1;
        tx_fifo_cf = cf_force || (cf_rand && $urandom_range(0, 2) == 0);
    end

    // Echo scoreboard and per-cycle protocol checks.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (tx_fifo_we) begin
                check("we_while_cf", tx_fifo_cf, 0);
                if (exp_echo.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL echo_extra: got 0x%0h expected no write at %0t", tx_fifo_wr_data, $time);
                end else check("echo_byte", tx_fifo_wr_data, exp_echo.pop_front());
            end
            if (line_ovf) n_ovf++;
            if (line_rdy) check("re_in_hold", rx_fifo_re, 0);
        end
    end

    // Line consumer: checks length and contents, then acknowledges after a random delay.
    initial forever begin
        int l;
        int len0;
        @(negedge clk);
        if (!reset && line_rdy) begin
            l = exp_len.size() != 0 ? exp_len.pop_front() : -1;
            len0 = line_len;
            check("line_len", line_len, l);
            for (int i = 0; i < l; i++) begin
                @(posedge clk);
                #1 line_rd_addr = AW'(i);
                @(posedge clk);
                @(negedge clk);
                check("line_byte", line_rd_data, exp_bytes.pop_front());
            end
            repeat ($urandom_range(3, 10)) @(posedge clk);
            #1;
            check("rdy_held", line_rdy, 1);
            check("len_stable", line_len, len0);
            line_ack = 1'b1;
            @(posedge clk);
            #1 line_ack = 1'b0;
            check("rdy_clear", line_rdy, 0);
            check("len_clear", line_len, 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int ovf0, re0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_re", rx_fifo_re, 0);
        check("rst_we", tx_fifo_we, 0);
        check("rst_wdata", tx_fifo_wr_data, 0);
        check("rst_rdy", line_rdy, 0);
        check("rst_len", line_len, 0);
        check("rst_ovf", line_ovf, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        send_str("AB"); send(8'h0D);
        drain();

        send_str("AX"); send(8'h7F); send_str("C"); send(8'h0D);
        drain();

        // ack outside HOLD must not clear a partial line
        send_str("XY");
        drain();
        line_ack = 1'b1;
        @(posedge clk);
        #1 line_ack = 1'b0;
        @(posedge clk);
        #1 check("ack_ignored", line_len, mline.size());
        send(8'h0D);
        drain();

        ovf0 = n_ovf;
        for (int i = 0; i < 65; i++) send(8'h61 + 8'(i % 26));
        send(8'h0D);
        drain();
        check("ovf_pulses", n_ovf - ovf0, 1);

        cf_force = 1'b1;
        send_str("Z");
        repeat (20) @(posedge clk);
        #1 cf_force = 1'b0;
        send(8'h0D);
        drain();

        send_str("Q"); send(8'h0D); send_str("abc");
        drain();
        send(8'h0D);
        drain();

        re0 = n_re;
        send(8'h0D); send(8'h0A); send(8'h01);
        drain();
        check("crlf_re_pulses", n_re - re0, 3);
        check("crlf_no_line", line_rdy, 0);

        cf_rand = 1'b1;
        repeat (8) begin
            repeat ($urandom_range(1, 60)) begin
                send(rnd_byte());
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1;
        end
        repeat (70) send(8'($urandom_range(32, 126)));
        send(8'h0D);
        drain();
        cf_rand = 1'b0;

        check("re_total", n_re, n_sent);
        check("echo_left", exp_echo.size(), 0);
        check("lines_left", exp_len.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_line_edit.md
UART_LINE_EDIT -- requirements
Module: uart_line_edit

Interface
REQ-001 Parameter LINE_LEN, default 64, SHALL set the line buffer depth in bytes; legal values are 2^ADDRWIDTH.
REQ-002 Parameter ADDRWIDTH, default 6, SHALL set the line buffer address width.
REQ-003 Port clk  in  1  SHALL be the single clock.
REQ-004 Port reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Ports rx_fifo_rd_data  in  8, rx_fifo_ne  in  1, rx_fifo_re  out  1 SHALL consume the UART receive FIFO (show-ahead: data valid while ne).
REQ-006 Ports tx_fifo_wr_data  out  8, tx_fifo_we  out  1, tx_fifo_cf  in  1 SHALL feed echo bytes to the UART transmit FIFO.
REQ-007 Ports line_rdy  out  1, line_len  out  ADDRWIDTH+1, line_ack  in  1 SHALL hand a completed line to the host.
REQ-008 Ports line_rd_addr  in  ADDRWIDTH, line_rd_data  out  8 SHALL read the line buffer.
REQ-009 Port line_ovf  out  1 SHALL pulse one cycle per printable byte dropped because the buffer is full.

Function
REQ-010 States: IDLE, PROC, ECHO, HOLD.
REQ-011 IDLE with rx_fifo_ne=1: at the next edge, the block SHALL register rx_fifo_re=1 for exactly one cycle, capture rx_fifo_rd_data, and enter PROC. rx_fifo_ne SHALL NOT be sampled in the cycle in which rx_fifo_re is high.
REQ-012 PROC, printable byte (0x20..0x7E) with len<LINE_LEN: write buf[len], len+1, queue echo of the byte, go to ECHO.
REQ-013 PROC, printable byte with len==LINE_LEN: drop the byte, pulse line_ovf, queue BEL (0x07), go to ECHO.
REQ-014 PROC, 0x08 or 0x7F with len>0: len-1, queue BS SP BS (0x08 0x20 0x08), go to ECHO. With len==0: discard, return to IDLE.
REQ-015 PROC, CR (0x0D) or LF (0x0A) with len>0: queue CR LF, set the line-done flag, go to ECHO. With len==0: discard silently and return to IDLE (this absorbs the second byte of a CRLF pair).
REQ-016 PROC, any other byte: discard with no echo, return to IDLE.
REQ-017 ECHO SHALL emit one queued byte per cycle, with tx_fifo_we=1 only when tx_fifo_cf=0; a full FIFO SHALL stall without loss or duplication.
REQ-018 When the ECHO queue empties, the block SHALL enter HOLD if the line-done flag is set, otherwise IDLE.
REQ-019 HOLD: line_rdy=1 and line_len stable; rx_fifo_re SHALL stay 0, which backpressures into the UART.
REQ-020 A line_ack sampled in HOLD SHALL clear line_rdy and len at the next edge and return to IDLE; line_ack outside HOLD SHALL be ignored.
REQ-021 line_rd_data SHALL be registered buf[line_rd_addr] with 1-cycle latency; bytes at or above line_len are undefined.
REQ-022 line_len SHALL equal the internal len at all times and saturate at LINE_LEN; arithmetic is unsigned with no wrap.

Reset
REQ-023 Reset SHALL force IDLE, len=0, and line_rdy, rx_fifo_re, tx_fifo_we, line_ovf, tx_fifo_wr_data all to 0. Buffer contents are not cleared.
REQ-024 Reset mid-ECHO or mid-HOLD SHALL abandon queued echo bytes and the pending line.

Configuration
REQ-025 With UART_LINE_ECHO_EN defined, echo SHALL behave as in REQ-012..017. Without it, tx_fifo_we and tx_fifo_wr_data SHALL be tied 0, ECHO SHALL be skipped, and line_ovf behaviour is unchanged.

Structure
REQ-026 Package uart_pkg SHALL hold the ASCII constants (CR, LF, BS, DEL, BEL, SP) and the state encoding.
REQ-027 Sub-module uart_line_ram SHALL implement the buffer: one write port and one registered read port, LINE_LEN x 8.

Verification
REQ-028 Input "AB",0x0D: echo 0x41 0x42 0x0D 0x0A; line_rdy=1, line_len=2; reading addr 0 and 1 returns 0x41 and 0x42.
REQ-029 Input "AX",0x7F,"C",0x0D: echo includes 0x08 0x20 0x08; final line "AC", line_len=2.
REQ-030 Send 65 printable bytes, then CR: exactly one line_ovf pulse, echo 0x07, line_len=64.
REQ-031 Hold tx_fifo_cf=1 for 20 cycles during echo of "Z": exactly one 0x5A write, issued after cf falls.
REQ-032 Line pending, 3 more bytes queued in the RX FIFO, no line_ack: rx_fifo_re stays 0. After line_ack, bytes resume and len restarts at 0.
REQ-033 Input 0x0D 0x0A with len=0, then 0x01: no echo, no line_rdy, rx_fifo_re pulses 3 times.
